// File: rtl/ssd_scan_arbiter.sv
// Eight-digit seven-segment scanner shared by two requesters through a
// frame-aligned arbiter; the shown word is latched once per frame.
module ssd_scan_arbiter #(
   parameter int unsigned SCAN_DIV    = 18,
   parameter int unsigned HOLD_FRAMES = 4
) (
   input  logic        ClkPort,
   input  logic        Reset,
   input  logic        req_a,
   input  logic [31:0] data_a,
   input  logic        req_b,
   input  logic [31:0] data_b,
   input  logic        blank_lz,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic [7:0]  An,
   output logic [7:0]  Cathodes,
   output logic        frame_done
);

   localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   logic [SCAN_DIV-1:0] cnt;
   logic [2:0]          idx;
   state_t              state, state_next;
   logic [HOLD_W-1:0]   hold, hold_next;
   logic [31:0]         word, word_next;
   logic                tick_c, boundary_c;
   logic [3:0]          nib_c;
   logic [7:0]          upper_zero_c;
   logic                blanked_c;
   logic [7:0]          an_next, cat_next;

   // Active-low {a,b,c,d,e,f,g,dp}; dp is never lit.
   function automatic logic [7:0] seg_decode(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'h0: s = 8'h03;
         4'h1: s = 8'h9F;
         4'h2: s = 8'h25;
         4'h3: s = 8'h0D;
         4'h4: s = 8'h99;
         4'h5: s = 8'h49;
         4'h6: s = 8'h41;
         4'h7: s = 8'h1F;
         4'h8: s = 8'h01;
         4'h9: s = 8'h09;
         4'hA: s = 8'h11;
         4'hB: s = 8'hC1;
         4'hC: s = 8'h63;
         4'hD: s = 8'h85;
         4'hE: s = 8'h61;
         default: s = 8'h71;
      endcase
      return s;
   endfunction

   assign tick_c     = &cnt;
   assign boundary_c = tick_c && (idx == 3'd7);

   // Prescaler, digit index and frame pulse.
   always_ff @(posedge ClkPort) begin
      if (Reset) begin
         cnt        <= '0;
         idx        <= '0;
         frame_done <= 1'b0;
      end else begin
         cnt        <= cnt + SCAN_DIV'(1);
         frame_done <= boundary_c;
         if (tick_c) begin
            idx <= idx + 3'd1;
         end
      end
   end

   // Arbiter state, hold counter, latched word and grants.
   always_ff @(posedge ClkPort) begin
      if (Reset) begin
         state <= IDLE;
         hold  <= '0;
         word  <= '0;
         gnt_a <= 1'b0;
         gnt_b <= 1'b0;
      end else begin
         state <= state_next;
         hold  <= hold_next;
         word  <= word_next;
         gnt_a <= (state_next == OWN_A);
         gnt_b <= (state_next == OWN_B);
      end
   end

   // Ownership only moves on frame boundaries so a frame is never torn.
   always_comb begin
      state_next = state;
      hold_next  = hold;
      word_next  = word;
      if (boundary_c) begin
         case (state)
            IDLE: begin
               hold_next = '0;
               if (req_a) begin
                  state_next = OWN_A;
               end else if (req_b) begin
                  state_next = OWN_B;
               end
            end
            OWN_A: begin
               if (hold < HOLD_MAX) begin
                  hold_next = hold + HOLD_W'(1);
               end else if (req_b) begin
                  state_next = OWN_B;
                  hold_next  = '0;
               end else if (!req_a) begin
                  state_next = IDLE;
                  hold_next  = '0;
               end
            end
            OWN_B: begin
               if (hold < HOLD_MAX) begin
                  hold_next = hold + HOLD_W'(1);
               end else if (req_a) begin
                  state_next = OWN_A;
                  hold_next  = '0;
               end else if (!req_b) begin
                  state_next = IDLE;
                  hold_next  = '0;
               end
            end
            default: begin
               state_next = IDLE;
               hold_next  = '0;
            end
         endcase
         case (state_next)
            OWN_A:   word_next = data_a;
            OWN_B:   word_next = data_b;
            default: word_next = '0;
         endcase
      end
   end

   // upper_zero_c[i]: nibbles i..7 of the latched word are all zero.
   always_comb begin
      upper_zero_c    = '0;
      upper_zero_c[7] = (word[31:28] == 4'h0);
      for (int i = 6; i >= 0; i--) begin
         upper_zero_c[i] = upper_zero_c[i+1] && (word[4*i +: 4] == 4'h0);
      end
   end

   assign nib_c     = word[{idx, 2'b00} +: 4];
   assign blanked_c = blank_lz && (idx != 3'd0) && upper_zero_c[idx];

   always_comb begin
      an_next  = 8'hFF;
      cat_next = 8'hFF;
      if (state != IDLE) begin
         cat_next = seg_decode(nib_c);
         if (!blanked_c) begin
            an_next = ~(8'd1 << idx);
         end
      end
   end

   always_ff @(posedge ClkPort) begin
      if (Reset) begin
         An       <= 8'hFF;
         Cathodes <= 8'hFF;
      end else begin
         An       <= an_next;
         Cathodes <= cat_next;
      end
   end

endmodule
